adder_arbiter: RTL and testbench

- Shares one W-bit adder datapath (sum = x + y + cin, W+1-bit result, zero flag) among NREQ requesters.
- Each requester presents operands through a valid/ready handshake. The block grants round-robin, registers the sum, and returns it with the requester id on a single valid/ready response port.
- Sits between client blocks and the shared add resource. Sustains one add per cycle when the response port is not stalled.

---
 rtl/adder_arbiter.sv | 155 +++++++++++++++
 tb/tb_adder_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one W-bit adder among NREQ requesters, with a
// single-slot registered response. Optional counters under ADDER_ARB_STATS_EN.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_sum,
  output logic              rsp_zero,
  output logic              busy
`ifdef ADDER_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_stalls
`endif
);

  logic           rsp_valid_q, rsp_valid_d;
  logic [W:0]     rsp_sum_q, rsp_sum_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           can_issue;
  logic           grant_found;
  logic           handshake;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand_idx;
  logic [W-1:0]   grant_x;
  logic [W-1:0]   grant_y;
  logic           grant_cin;
  logic [W:0]     grant_sum;

  assign can_issue = !rsp_valid_q || rsp_ready;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_idx = IDW'((32'(ptr_q) + 32'(i)) % 32'(NREQ));
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign handshake = !rst && can_issue && grant_found;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_x   = '0;
    grant_y   = '0;
    grant_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_x   = req_x[i*W +: W];
        grant_y   = req_y[i*W +: W];
        grant_cin = req_cin[i];
      end
    end
  end

  assign grant_sum = {1'b0, grant_x} + {1'b0, grant_y} + {{W{1'b0}}, grant_cin};

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (handshake) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = grant_sum;
      rsp_zero_d  = (grant_sum == '0);
      rsp_id_d    = grant_idx;
      ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid_q || (|req_valid);

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] stat_grants_q, stat_grants_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stalls_d = stat_stalls_q;
    if (stat_clr) begin
      stat_grants_d = '0;
      stat_stalls_d = '0;
    end else begin
      if (handshake && !(&stat_grants_q))
        stat_grants_d = stat_grants_q + 16'd1;
      if (rsp_valid_q && !rsp_ready && !(&stat_stalls_q))
        stat_stalls_d = stat_stalls_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed table, hand-written corner
// sequences, then randomized traffic against a queue-free behavioural model.
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              rsp_zero;
  logic              busy;
`ifdef ADDER_ARB_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat_grants;
  logic [15:0]       stat_stalls;
`endif

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_zero(rsp_zero),
    .busy(busy)
`ifdef ADDER_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int       idx;
    logic [7:0] x;
    logic [7:0] y;
    logic     cin;
    logic [8:0] exp_sum;
    logic     exp_zero;
  } vec_t;

  vec_t vecs[6];

  // Behavioural model state for the random phase
  int         m_ptr;
  bit         m_valid;
  int         m_sum;
  int         m_id;
  bit         pend[NREQ];
  logic [7:0] px[NREQ];
  logic [7:0] py[NREQ];
  logic       pc[NREQ];
  int         waits[NREQ];

  function automatic logic [7:0] pick_operand();
    int r;
    r = int'($urandom % 8);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  task automatic drive_pending();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_x[i*W +: W]    = px[i];
      req_y[i*W +: W]    = py[i];
      req_cin[i]         = pc[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'h12, 8'h34, 1'b1, 9'h047, 1'b0};
    vecs[1] = '{1, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
    vecs[2] = '{2, 8'h00, 8'h00, 1'b0, 9'h000, 1'b1};
    vecs[3] = '{3, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
    vecs[4] = '{0, 8'h80, 8'h7F, 1'b1, 9'h100, 1'b0};
    vecs[5] = '{3, 8'h00, 8'h00, 1'b1, 9'h001, 1'b0};

    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_cin = '0; rsp_ready = 1'b0;
`ifdef ADDER_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    step();
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'h0);
    step();
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
    check("reset_rsp_zero", 32'(rsp_zero), 32'h0);
    rst = 1'b0; req_valid = '0;
    #1;
    check("idle_busy", 32'(busy), 32'h0);
    step();

    // Single-requester vectors, one per cycle
    for (int v = 0; v < 6; v++) begin
      req_valid = '0;
      req_valid[vecs[v].idx] = 1'b1;
      req_x[vecs[v].idx*W +: W] = vecs[v].x;
      req_y[vecs[v].idx*W +: W] = vecs[v].y;
      req_cin[vecs[v].idx] = vecs[v].cin;
      rsp_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(1) << vecs[v].idx);
      step();
      req_valid = '0;
      check($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
      check($sformatf("vec%0d_rsp_sum", v), 32'(rsp_sum), 32'(vecs[v].exp_sum));
      check($sformatf("vec%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].idx));
      check($sformatf("vec%0d_rsp_zero", v), 32'(rsp_zero), 32'(vecs[v].exp_zero));
    end

    // Drain with no new request
    req_valid = '0; rsp_ready = 1'b1;
    step();
    check("drain_rsp_valid", 32'(rsp_valid), 32'h0);

    // Round-robin with all requesters valid; ptr is 0 after the last grant to 3
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = 8'(i);
      req_y[i*W +: W] = 8'h10;
      req_cin[i] = 1'b0;
    end
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(1) << (k % NREQ));
      step();
      check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
      check($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(k % NREQ));
      check($sformatf("rr%0d_rsp_sum", k), 32'(rsp_sum), 32'(16 + (k % NREQ)));
    end

    // Backpressure: slot holds id 3 / 0x13, ptr is 0
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d_req_ready", k), 32'(req_ready), 32'h0);
      step();
      check($sformatf("stall%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
      check($sformatf("stall%0d_rsp_id", k), 32'(rsp_id), 32'h3);
      check($sformatf("stall%0d_rsp_sum", k), 32'(rsp_sum), 32'h13);
    end
    rsp_ready = 1'b1;
    #1;
    check("unstall_req_ready", 32'(req_ready), 32'h1);
    step();
    check("unstall_rsp_id", 32'(rsp_id), 32'h0);
    check("unstall_rsp_sum", 32'(rsp_sum), 32'h10);

    // Grant req1 so ptr moves to 2, then reset with req2 pending and slot full
    req_valid = 4'b0010;
    #1;
    check("prerst_req_ready", 32'(req_ready), 32'h2);
    step();
    check("prerst_rsp_id", 32'(rsp_id), 32'h1);
    req_valid = 4'b0100; rsp_ready = 1'b0; rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    step();
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_sum", 32'(rsp_sum), 32'h0);
    check("midrst_rsp_id", 32'(rsp_id), 32'h0);
    rst = 1'b0; req_valid = 4'b0110; rsp_ready = 1'b1;
    #1;
    check("postrst_req_ready", 32'(req_ready), 32'h2);
    step();
    check("postrst_rsp_id", 32'(rsp_id), 32'h1);
    check("postrst_rsp_sum", 32'(rsp_sum), 32'h11);

`ifdef ADDER_ARB_STATS_EN
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    check("stat_reset_grants", 32'(stat_grants), 32'h0);
    check("stat_reset_stalls", 32'(stat_stalls), 32'h0);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    req_valid = '0; rsp_ready = 1'b0;
    for (int k = 0; k < 2; k++) step();
    check("stat_grants_3", 32'(stat_grants), 32'h3);
    check("stat_stalls_2", 32'(stat_stalls), 32'h2);
    req_valid = 4'b0001; rsp_ready = 1'b1; stat_clr = 1'b1;
    #1;
    check("stat_clr_req_ready", 32'(req_ready), 32'h1);
    step();
    stat_clr = 1'b0; req_valid = '0;
    check("stat_clr_grants", 32'(stat_grants), 32'h0);
    check("stat_clr_stalls", 32'(stat_stalls), 32'h0);
`endif

    // Randomized traffic against the model, starting from a fresh reset
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_sum = 0; m_id = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; px[i] = '0; py[i] = '0; pc[i] = 1'b0; waits[i] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      bit can;
      bit any_pend;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          px[i] = pick_operand();
          py[i] = pick_operand();
          pc[i] = 1'($urandom);
        end
      end
      rsp_ready = ($urandom % 4) != 0;
      drive_pending();

      can = !m_valid || rsp_ready;
      g = -1;
      if (can) begin
        for (int k = 0; k < NREQ && g < 0; k++) begin
          if (pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      any_pend = 1'b0;
      for (int i = 0; i < NREQ; i++) any_pend |= pend[i];

      #1;
      check("rnd_req_ready", 32'(req_ready), (g >= 0) ? (32'(1) << g) : 32'h0);
      check("rnd_busy", 32'(busy), 32'(m_valid || any_pend));
      step();

      if (g >= 0) begin
        check("rnd_fairness_wait", 32'(waits[g] < NREQ), 32'h1);
        waits[g] = 0;
        for (int i = 0; i < NREQ; i++) if (i != g && pend[i]) waits[i]++;
        m_valid = 1'b1;
        m_sum   = int'(px[g]) + int'(py[g]) + int'(pc[g]);
        m_id    = g;
        m_ptr   = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end

      check("rnd_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("rnd_rsp_sum", 32'(rsp_sum), 32'(m_sum));
        check("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
        check("rnd_rsp_zero", 32'(rsp_zero), 32'(m_sum == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
